// File: rtl/ph_bht_predictor.sv
// Private-history branch history table: per-entry local history selects one of
// 2**HIST_LEN saturating 2-bit counters. Same-cycle lookup, registered training, sequential flush.
module ph_bht_predictor #(
  parameter int unsigned VLEN       = 32,
  parameter int unsigned NR_ENTRIES = 32,
  parameter int unsigned HIST_LEN   = 3,
  parameter int unsigned RVC        = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            debug_mode_i,
  input  logic            vpc_valid_i,
  input  logic [VLEN-1:0] vpc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  output logic            busy_o,
  input  logic            upd_valid_i,
  input  logic [VLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i
);
  localparam int unsigned IDX_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
  localparam int unsigned OFF   = (RVC != 0) ? 1 : 2;
  localparam int unsigned NCNT  = 1 << HIST_LEN;

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  logic [HIST_LEN-1:0] r_hist [NR_ENTRIES];
  logic [1:0]          r_cnt  [NR_ENTRIES][NCNT];
  state_e              r_state;
  logic [IDX_W-1:0]    r_fcnt;

  logic [IDX_W-1:0]    w_lk_idx, w_up_idx;
  logic [HIST_LEN-1:0] w_lk_h, w_up_h, w_hist_nxt;
  logic [1:0]          w_up_cnt, w_cnt_nxt;
  logic                w_upd_en;
  logic                w_unused;

  // Upper PC bits never reach the index; aliasing between them is intended.
  assign w_unused = ^{vpc_i, upd_pc_i};

  assign w_lk_idx = vpc_i[OFF+IDX_W-1:OFF];
  assign w_lk_h   = r_hist[w_lk_idx];

  assign pred_taken_o = r_cnt[w_lk_idx][w_lk_h][1];
  assign pred_valid_o = vpc_valid_i & (r_state == S_IDLE);
  assign busy_o       = (r_state == S_FLUSH);

  assign w_upd_en = upd_valid_i & ~debug_mode_i & (r_state == S_IDLE);
  assign w_up_idx = upd_pc_i[OFF+IDX_W-1:OFF];
  assign w_up_h   = r_hist[w_up_idx];
  assign w_up_cnt = r_cnt[w_up_idx][w_up_h];

  always_comb begin
    w_cnt_nxt = w_up_cnt;
    if (upd_taken_i) begin
      if (w_up_cnt != 2'b11) w_cnt_nxt = w_up_cnt + 2'b01;
    end else begin
      if (w_up_cnt != 2'b00) w_cnt_nxt = w_up_cnt - 2'b01;
    end
  end

  generate
    if (HIST_LEN == 1) begin : g_hist1
      assign w_hist_nxt = upd_taken_i;
    end else begin : g_histn
      assign w_hist_nxt = {w_up_h[HIST_LEN-2:0], upd_taken_i};
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e < NR_ENTRIES; e++) begin
        r_hist[e] <= '0;
        for (int c = 0; c < NCNT; c++) r_cnt[e][c] <= 2'b01;
      end
      r_state <= S_IDLE;
      r_fcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A training write in the flush-request cycle still lands; the flush wipes it later.
          if (w_upd_en) begin
            r_cnt[w_up_idx][w_up_h] <= w_cnt_nxt;
            r_hist[w_up_idx]        <= w_hist_nxt;
          end
          if (flush_i) begin
            r_state <= S_FLUSH;
            r_fcnt  <= '0;
          end
        end
        S_FLUSH: begin
          r_hist[r_fcnt] <= '0;
          for (int c = 0; c < NCNT; c++) r_cnt[r_fcnt][c] <= 2'b01;
          if (flush_i)                               r_fcnt  <= '0;
          else if (r_fcnt == IDX_W'(NR_ENTRIES - 1)) r_state <= S_IDLE;
          else                                       r_fcnt  <= r_fcnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  generate
    if (NR_ENTRIES < 2 || (NR_ENTRIES & (NR_ENTRIES - 1)) != 0) begin : g_bad_entries
      $error("NR_ENTRIES must be a power of 2 and >= 2");
    end
    if (HIST_LEN < 1 || HIST_LEN > 4) begin : g_bad_hist
      $error("HIST_LEN must be in 1..4");
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_i)
      assert (!$isunknown({pred_valid_o, pred_taken_o, busy_o}))
        else $error("X on predictor outputs");
  end
`endif
endmodule

// File: tb/tb_ph_bht_predictor.sv
// Randomized and directed bench for ph_bht_predictor against an array-based reference model.
module tb_ph_bht_predictor;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1, flush_i = 1'b0, debug_mode_i = 1'b0;
  logic        vpc_valid_i = 1'b0, upd_valid_i = 1'b0, upd_taken_i = 1'b0;
  logic [31:0] vpc_i = '0, upd_pc_i = '0;
  logic        pred_valid_o, pred_taken_o, busy_o;

  always #5 clk = ~clk;

  ph_bht_predictor #(.VLEN(32), .NR_ENTRIES(32), .HIST_LEN(3), .RVC(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
    .vpc_valid_i(vpc_valid_i), .vpc_i(vpc_i),
    .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .busy_o(busy_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i));

  int    checks = 0, failures = 0;
  string phase = "init";
  bit    obs_busy;

  // Reference: history as an integer 0..7, counters as integers 0..3.
  int m_hist [32];
  int m_cnt  [32][8];
  bit m_flushing;
  int m_pos;

  function automatic int idx(input logic [31:0] pc);
    return int'((pc / 2) % 32);
  endfunction

  function automatic void m_clear(input int e);
    m_hist[e] = 0;
    for (int c = 0; c < 8; c++) m_cnt[e][c] = 1;
  endfunction

  function automatic void m_reset();
    for (int e = 0; e < 32; e++) m_clear(e);
    m_flushing = 0;
    m_pos = 0;
  endfunction

  function automatic void m_tick(input bit f, input bit d, input bit uv,
                                 input logic [31:0] upc, input bit ut);
    if (!m_flushing) begin
      if (uv && !d) begin
        int i, h;
        i = idx(upc);
        h = m_hist[i];
        m_cnt[i][h] = ut ? ((m_cnt[i][h] == 3) ? 3 : m_cnt[i][h] + 1)
                         : ((m_cnt[i][h] == 0) ? 0 : m_cnt[i][h] - 1);
        m_hist[i] = (h * 2 + int'(ut)) % 8;
      end
      if (f) begin m_flushing = 1; m_pos = 0; end
    end else begin
      m_clear(m_pos);
      if (f)                m_pos = 0;
      else if (m_pos == 31) m_flushing = 0;
      else                  m_pos++;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit f, input bit d, input bit vv,
                      input logic [31:0] vpc, input bit uv, input logic [31:0] upc,
                      input bit ut, input int exp_tk = -1);
    int  i;
    bit  exp_taken;
    @(negedge clk);
    rst_i = r; flush_i = f; debug_mode_i = d; vpc_valid_i = vv; vpc_i = vpc;
    upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut;
    if (r) m_reset();
    #1;
    i = idx(vpc);
    exp_taken = (m_cnt[i][m_hist[i]] >= 2);
    check({phase, ".pred_valid"}, 32'(pred_valid_o), 32'(vv && !m_flushing));
    check({phase, ".pred_taken"}, 32'(pred_taken_o), 32'(exp_taken));
    check({phase, ".busy"}, 32'(busy_o), 32'(m_flushing));
    if (exp_tk >= 0) check({phase, ".directed_taken"}, 32'(pred_taken_o), 32'(exp_tk));
    obs_busy = busy_o;
    @(posedge clk);
    if (!r) m_tick(f, d, uv, upc, ut);
  endtask

  task automatic idle_look(input logic [31:0] vpc, input int exp_tk = -1);
    step(0, 0, 0, 1, vpc, 0, 32'h0, 0, exp_tk);
  endtask

  // Counts busy cycles following a flush request; upd_at injects a dropped update.
  task automatic count_busy(input string tag, input int upd_at);
    int n = 0;
    for (int k = 0; k < 100; k++) begin
      step(0, 0, 0, 1, 32'h100, (k == upd_at), 32'h100, 1);
      if (!obs_busy) break;
      n++;
    end
    check(tag, 32'(n), 32'd32);
  endtask

  initial begin
    m_reset();
    phase = "reset";
    step(1, 0, 0, 1, 32'h8000_0000, 0, 32'h0, 0, 0);
    step(1, 1, 0, 1, 32'h8000_0000, 1, 32'h100, 1, 0);
    idle_look(32'h8000_0000, 0);

    phase = "train";
    step(0, 0, 0, 1, 32'h100, 1, 32'h100, 1, 0);  // h=0
    step(0, 0, 0, 1, 32'h100, 1, 32'h100, 1, 0);  // h=1
    step(0, 0, 0, 1, 32'h100, 1, 32'h100, 1, 0);  // h=3
    step(0, 0, 0, 1, 32'h100, 1, 32'h100, 1, 0);  // h=7: lookup sees pre-update 01
    step(0, 0, 0, 1, 32'h100, 1, 32'h100, 1, 1);  // h=7 now 10
    step(0, 0, 0, 1, 32'h100, 1, 32'h100, 1, 1);  // saturate at 11
    idle_look(32'h100, 1);

    phase = "alias";
    step(0, 0, 0, 1, 32'h140, 1, 32'h140, 0, 1);
    idle_look(32'h100, 0);

    phase = "debug";
    step(0, 0, 1, 1, 32'h100, 1, 32'h100, 0, 0);
    step(0, 0, 1, 1, 32'h100, 1, 32'h100, 1, 0);
    idle_look(32'h100, 0);

    phase = "flush";
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 32'h0, 1, 32'h100, 1);
    step(0, 1, 0, 1, 32'h100, 1, 32'h100, 1);
    count_busy("flush_len", 5);
    for (int k = 0; k < 8; k++) idle_look($urandom, 0);

    phase = "reflush";
    step(0, 1, 0, 1, 32'h100, 0, 32'h0, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 1, 32'h100, 0, 32'h0, 0);
    step(0, 1, 0, 1, 32'h100, 0, 32'h0, 0);
    count_busy("reflush_len", -1);

    phase = "rst_mid_flush";
    step(0, 1, 0, 1, 32'h100, 0, 32'h0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 32'h100, 0, 32'h0, 0);
    step(1, 0, 0, 1, 32'h100, 0, 32'h0, 0);
    check("rst_mid_flush.busy_now", 32'(obs_busy), 32'd0);
    idle_look(32'h100, 0);

    phase = "random";
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] vpc, upc;
      vpc = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7) << 1);
      upc = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7) << 1);
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) == 0), 1'($urandom), vpc,
           1'($urandom), upc, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
